// File: rtl/tt_um_ternary_mac.sv
// rtl/tt_um_ternary_mac.sv - ternary-weight matrix-vector MAC with streaming in/out
// Define TERNARY_MAC_SAT_EN to saturate results to the IN_W signed range.
module tt_um_ternary_mac #(
  parameter int MAX_IN_LEN   = 16,
  parameter int MAX_OUT_LEN  = 8,
  parameter int WIDTH        = 2,
  parameter int IN_W         = 8,
  parameter int MAX_IN_BITS  = $clog2(MAX_IN_LEN),
  parameter int MAX_OUT_BITS = $clog2(MAX_OUT_LEN),
  parameter int ACC_W        = IN_W + MAX_IN_BITS + 1
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  ena,
  input  logic [WIDTH*MAX_IN_LEN*MAX_OUT_LEN-1:0] ui_weights,
  input  logic [MAX_IN_BITS+MAX_OUT_BITS-1:0]   ui_param,
  input  logic                                  ui_start,
  input  logic [IN_W-1:0]                       ui_in_data,
  input  logic                                  ui_in_valid,
  output logic                                  uo_in_ready,
  output logic [ACC_W-1:0]                      uo_out_data,
  output logic                                  uo_out_valid,
  input  logic                                  ui_out_ready,
  output logic                                  uo_out_last,
  output logic                                  uo_busy,
  output logic                                  uo_done
);

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} state_t;

  state_t                   state, state_nxt;
  logic [MAX_IN_BITS-1:0]   in_cnt, in_last;
  logic [MAX_OUT_BITS-1:0]  out_cnt, out_last;
  logic signed [ACC_W-1:0]  acc   [MAX_OUT_LEN];
  logic signed [ACC_W-1:0]  delta [MAX_OUT_LEN];
  logic [WIDTH-1:0]         wmat  [MAX_IN_LEN][MAX_OUT_LEN];
  logic signed [ACC_W-1:0]  x_ext, acc_sel, out_val;
  logic                     in_fire, out_fire, done_q;

  // Reshape the flat weight bus so the current input row can be indexed by in_cnt.
  for (genvar gi = 0; gi < MAX_IN_LEN; gi++) begin : g_row
    for (genvar gj = 0; gj < MAX_OUT_LEN; gj++) begin : g_col
      assign wmat[gi][gj] = ui_weights[gi*WIDTH*MAX_OUT_LEN + gj*WIDTH +: WIDTH];
    end
  end

  assign x_ext    = {{(ACC_W-IN_W){ui_in_data[IN_W-1]}}, ui_in_data};
  assign in_fire  = uo_in_ready && ui_in_valid;
  assign out_fire = uo_out_valid && ui_out_ready;

  // Bit 0 enables the term, bit 1 selects negation (01=+1, 11=-1, x0=0).
  always_comb begin
    for (int j = 0; j < MAX_OUT_LEN; j++) begin
      delta[j] = '0;
      if (wmat[in_cnt][j][0]) delta[j] = wmat[in_cnt][j][1] ? -x_ext : x_ext;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (ena && ui_start)                     state_nxt = ACCUM;
      ACCUM:   if (in_fire && in_cnt == in_last)        state_nxt = DRAIN;
      DRAIN:   if (out_fire && out_cnt == out_last)     state_nxt = IDLE;
      default:                                          state_nxt = IDLE;
    endcase
  end

  always_comb begin
    acc_sel = acc[out_cnt];
`ifdef TERNARY_MAC_SAT_EN
    if ((&acc_sel[ACC_W-1:IN_W-1]) || !(|acc_sel[ACC_W-1:IN_W-1]))
      out_val = acc_sel;
    else
      out_val = {{(ACC_W-IN_W){acc_sel[ACC_W-1]}}, acc_sel[ACC_W-1], {(IN_W-1){~acc_sel[ACC_W-1]}}};
`else
    out_val = acc_sel;
`endif
    uo_in_ready  = ena && (state == ACCUM);
    uo_out_valid = ena && (state == DRAIN);
    uo_out_last  = uo_out_valid && (out_cnt == out_last);
    uo_out_data  = (state == DRAIN) ? out_val : '0;
    uo_busy      = (state != IDLE);
    uo_done      = done_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_cnt   <= '0;
      in_last  <= '0;
      out_cnt  <= '0;
      out_last <= '0;
      done_q   <= 1'b0;
      for (int j = 0; j < MAX_OUT_LEN; j++) acc[j] <= '0;
    end else begin
      done_q <= out_fire && (out_cnt == out_last);
      if (ena) begin
        case (state)
          IDLE: if (ui_start) begin
            out_last <= ui_param[MAX_OUT_BITS-1:0];
            in_last  <= ui_param[MAX_IN_BITS+MAX_OUT_BITS-1:MAX_OUT_BITS];
            in_cnt   <= '0;
            out_cnt  <= '0;
            for (int j = 0; j < MAX_OUT_LEN; j++) acc[j] <= '0;
          end
          ACCUM: if (in_fire) begin
            for (int j = 0; j < MAX_OUT_LEN; j++) acc[j] <= acc[j] + delta[j];
            in_cnt <= in_cnt + 1'b1;
          end
          DRAIN: if (out_fire) out_cnt <= out_cnt + 1'b1;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tt_um_ternary_mac.sv
// tb/tb_tt_um_ternary_mac.sv - scoreboard bench for tt_um_ternary_mac
module tb_tt_um_ternary_mac;
  localparam int MI = 16, MO = 8, W = 2, IW = 8, ACCW = 13;

  logic clk = 0, rst_n = 0, ena = 1, ui_start = 0, ui_in_valid = 0, ui_out_ready = 1;
  logic [W*MI*MO-1:0] ui_weights = '0;
  logic [6:0]         ui_param = '0;
  logic [IW-1:0]      ui_in_data = '0;
  logic               uo_in_ready, uo_out_valid, uo_out_last, uo_busy, uo_done;
  logic [ACCW-1:0]    uo_out_data;

  tt_um_ternary_mac dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_weights(ui_weights), .ui_param(ui_param),
    .ui_start(ui_start), .ui_in_data(ui_in_data), .ui_in_valid(ui_in_valid),
    .uo_in_ready(uo_in_ready), .uo_out_data(uo_out_data), .uo_out_valid(uo_out_valid),
    .ui_out_ready(ui_out_ready), .uo_out_last(uo_out_last), .uo_busy(uo_busy), .uo_done(uo_done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_fail = 0;
  int exp_d[$];
  bit exp_l[$];
  int x_arr[MI];
  int out_mode = 0, done_cnt = 0, drain_cyc = 0, prev_data = 0, ena_left = 0;
  bit done_due = 0, prev_stall = 0, ena_used = 0, tog = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int wv(input logic [1:0] b);
    return (b == 2'b01) ? 1 : (b == 2'b11) ? -1 : 0;
  endfunction

  // Monitor: pops the scoreboard on every accepted result beat.
  always @(negedge clk) begin : mon
    int d;
    bit l;
    if (!rst_n) begin
      done_due = 0; prev_stall = 0; drain_cyc = 0;
    end else begin
      if (done_due || uo_done) begin
        check("done_pulse", int'(uo_done), int'(done_due));
        if (uo_done) done_cnt++;
      end
      done_due = 0;
      if (!uo_busy) drain_cyc = 0;
      if (!ena) begin
        check("ena_low_out_valid", int'(uo_out_valid), 0);
        check("ena_low_in_ready", int'(uo_in_ready), 0);
        check("ena_low_busy", int'(uo_busy), 1);
      end
      if (uo_out_valid) begin
        drain_cyc++;
        if (prev_stall) check("stall_stable", $signed(uo_out_data), prev_data);
        if (ui_out_ready) begin
          if (exp_d.size() == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL unexpected_beat: got %0d expected no beat", $signed(uo_out_data));
          end else begin
            d = exp_d.pop_front();
            l = exp_l.pop_front();
            check("out_data", $signed(uo_out_data), d);
            check("out_last", int'(uo_out_last), int'(l));
            done_due = l;
          end
        end
        prev_stall = !ui_out_ready;
        prev_data  = $signed(uo_out_data);
      end else if (ena) begin
        prev_stall = 0;
      end
    end
  end

  // Output-side driver: ready pattern and ena drop, chosen by out_mode.
  always @(posedge clk) begin
    #1;
    if (!uo_busy) ena_used = 0;
    case (out_mode)
      1:       ui_out_ready = ($urandom_range(0, 2) != 0);
      2:       ui_out_ready = !(drain_cyc >= 2 && drain_cyc < 5);
      default: ui_out_ready = 1;
    endcase
    if (ena_left > 0) begin
      ena_left--;
      ena = (ena_left == 0);
    end else if (out_mode == 3 && drain_cyc == 2 && !ena_used) begin
      ena = 0; ena_left = 4; ena_used = 1;
    end
  end

  task automatic feed(input int x, input int mode, input bit glitch);
    bit fired = 0;
    int t = 0;
    while (!fired && t < 50) begin
      tog = ~tog;
      case (mode)
        1:       ui_in_valid = $urandom_range(0, 1);
        2:       ui_in_valid = tog;
        default: ui_in_valid = 1;
      endcase
      ui_in_data = 8'(x);
      if (glitch) begin ui_start = 1; ui_param = 7'($urandom); end
      @(negedge clk);
      fired = ui_in_valid && uo_in_ready;
      @(posedge clk); #1;
      ui_start = 0;
      t++;
    end
    ui_in_valid = 0;
    if (!fired) begin
      n_cmp++; n_fail++;
      $display("FAIL in_beat_timeout: got no accept expected accept");
    end
  endtask

  task automatic start_job(input int il, input int ol);
    ui_param = 7'(((il - 1) << 3) | (ol - 1));
    ui_start = 1;
    @(posedge clk); #1;
    ui_start = 0;
  endtask

  task automatic run_job(input int il, input int ol, input int in_mode, input int om, input bit glitch);
    int s, base, tmo;
    for (int j = 0; j < ol; j++) begin
      s = 0;
      for (int i = 0; i < il; i++) s += x_arr[i] * wv(ui_weights[(i*MO + j)*W +: W]);
`ifdef TERNARY_MAC_SAT_EN
      if (s > 127) s = 127;
      if (s < -128) s = -128;
`endif
      exp_d.push_back(s);
      exp_l.push_back(j == ol - 1);
    end
    out_mode = om;
    start_job(il, ol);
    for (int i = 0; i < il; i++) feed(x_arr[i], in_mode, glitch && i == 0);
    base = done_cnt;
    tmo = 0;
    while (done_cnt == base && tmo < 400) begin @(posedge clk); tmo++; end
    if (done_cnt == base) begin
      n_cmp++; n_fail++;
      $display("FAIL done_timeout: got no uo_done expected uo_done");
    end
    check("queue_empty", exp_d.size(), 0);
    exp_d.delete();
    exp_l.delete();
    @(posedge clk); #1;
    out_mode = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, int'(uo_in_ready), 0);
    check({tag, "_out_valid"}, int'(uo_out_valid), 0);
    check({tag, "_out_last"}, int'(uo_out_last), 0);
    check({tag, "_busy"}, int'(uo_busy), 0);
    check({tag, "_done"}, int'(uo_done), 0);
    check({tag, "_out_data"}, int'(uo_out_data), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst_n = 1;

    // identity, no stalls, then same job with input gaps and output stall
    ui_weights = '0;
    for (int i = 0; i < 8; i++) begin ui_weights[(i*MO + i)*W +: W] = 2'b01; x_arr[i] = i + 1; end
    run_job(8, 8, 0, 0, 0);
    run_job(8, 8, 2, 2, 0);

    // negation, worst-case magnitude
    for (int k = 0; k < MI*MO; k++) ui_weights[k*W +: W] = 2'b11;
    for (int i = 0; i < MI; i++) x_arr[i] = -128;
    run_job(16, 8, 0, 0, 0);

    // ena drop mid-drain
    for (int k = 0; k < MI*MO; k++) ui_weights[k*W +: W] = 2'($urandom);
    for (int i = 0; i < MI; i++) x_arr[i] = int'($urandom_range(0, 255)) - 128;
    run_job(6, 8, 0, 3, 0);

    // reset after 5 accepted beats
    start_job(8, 8);
    for (int i = 0; i < 5; i++) feed(7, 0, 0);
    #2 rst_n = 0;
    #1 check_reset_outputs("mid_reset");
    @(posedge clk); #1;
    rst_n = 1;
    ui_weights = '0;
    for (int i = 0; i < 4; i++) begin ui_weights[(i*MO)*W +: W] = 2'b01; x_arr[i] = 10; end
    run_job(4, 1, 0, 0, 0);

    // minimum size with a start pulse during ACCUM
    ui_weights = '0;
    ui_weights[1:0] = 2'b11;
    x_arr[0] = -5;
    run_job(1, 1, 0, 0, 1);

    for (int r = 0; r < 6; r++) begin
      for (int k = 0; k < MI*MO; k++) ui_weights[k*W +: W] = 2'($urandom);
      for (int i = 0; i < MI; i++) x_arr[i] = int'($urandom_range(0, 255)) - 128;
      run_job(int'($urandom_range(1, 16)), int'($urandom_range(1, 8)),
              int'($urandom_range(0, 2)), int'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
